// File: rtl/t09_sound_pwm_out.sv
// PWM audio output stage with attack/sustain/release volume envelope.
// Ports: clk, rst (sync, active-high), sample_i[N], trigger_i -> pwm_o, active_o, env_o[4], strobe_o.
module t09_sound_pwm_out #(
  parameter int N           = 8,
  parameter int ATK_PERIODS = 1,
  parameter int SUS_PERIODS = 64,
  parameter int REL_PERIODS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sample_i,
  input  logic         trigger_i,
  output logic         pwm_o,
  output logic         active_o,
  output logic [3:0]   env_o,
  output logic         strobe_o
);

  localparam int PW = 16;
  localparam logic [PW-1:0] ATK_LAST = PW'(ATK_PERIODS - 1);
  localparam logic [PW-1:0] SUS_LAST = PW'(SUS_PERIODS - 1);
  localparam logic [PW-1:0] REL_LAST = PW'(REL_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [3:0]      env;
  logic [3:0]      env_d;
  logic [PW-1:0]   pcnt;
  logic [PW-1:0]   pcnt_d;
  logic [N-1:0]    pwm_cnt;
  logic [N-1:0]    duty;
  logic [N+3:0]    prod;
  logic            bound;

  assign bound = (pwm_cnt == {N{1'b1}});
  // env is the pre-update level, so the new duty reflects the
  // envelope that was in force during the period just ending
  assign prod  = (N+4)'(sample_i) * (N+4)'(env);
  assign env_o = env;

  always_comb begin
    state_d = state;
    env_d   = env;
    pcnt_d  = pcnt;
    unique case (state)
      IDLE: begin
        env_d  = 4'd0;
        pcnt_d = '0;
        if (trigger_i) begin
          state_d = ATTACK;
        end
      end
      ATTACK: begin
        if (bound) begin
          if (pcnt == ATK_LAST) begin
            pcnt_d = '0;
            // saturate at 15; a retrigger may enter here already at 15
            if (env >= 4'd14) begin
              env_d   = 4'd15;
              state_d = SUSTAIN;
            end else begin
              env_d = env + 4'd1;
            end
          end else begin
            pcnt_d = pcnt + 1'b1;
          end
        end
      end
      SUSTAIN: begin
        env_d = 4'd15;
        if (trigger_i) begin
          pcnt_d = '0;
        end else if (bound) begin
          if (pcnt == SUS_LAST) begin
            pcnt_d  = '0;
            state_d = RELEASE;
          end else begin
            pcnt_d = pcnt + 1'b1;
          end
        end
      end
      RELEASE: begin
        // retrigger resumes ATTACK from the current level
        if (trigger_i) begin
          pcnt_d  = '0;
          state_d = ATTACK;
        end else if (bound) begin
          if (pcnt == REL_LAST) begin
            pcnt_d = '0;
            if (env <= 4'd1) begin
              env_d   = 4'd0;
              state_d = IDLE;
            end else begin
              env_d = env - 4'd1;
            end
          end else begin
            pcnt_d = pcnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        env_d   = 4'd0;
        pcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      env      <= 4'd0;
      pcnt     <= '0;
      pwm_cnt  <= '0;
      duty     <= '0;
      pwm_o    <= 1'b0;
      active_o <= 1'b0;
      strobe_o <= 1'b0;
    end else begin
      state    <= state_d;
      env      <= env_d;
      pcnt     <= pcnt_d;
      active_o <= (state_d != IDLE);
      pwm_cnt  <= pwm_cnt + 1'b1;
      pwm_o    <= (pwm_cnt < duty);
      strobe_o <= bound;
      if (bound) begin
        duty <= prod[N+3:4];
      end
    end
  end

endmodule

// File: tb/tb_t09_sound_pwm_out.sv
// Directed bench for t09_sound_pwm_out.
// Ports: drives clk/rst/sample_i/trigger_i, checks pwm_o/active_o/env_o/strobe_o.
module tb_t09_sound_pwm_out;

  logic       clk;
  logic       rst;
  logic [7:0] sample_i;
  logic       trigger_i;
  logic       pwm_o;
  logic       active_o;
  logic [3:0] env_o;
  logic       strobe_o;

  int checks;
  int errors;
  int hi_cnt;
  int env_min;
  int n;
  int bad;
  int strobes;
  int first_sb;

  t09_sound_pwm_out #(
    .N(8),
    .ATK_PERIODS(1),
    .SUS_PERIODS(64),
    .REL_PERIODS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_i(sample_i),
    .trigger_i(trigger_i),
    .pwm_o(pwm_o),
    .active_o(active_o),
    .env_o(env_o),
    .strobe_o(strobe_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pwm_o) hi_cnt++;
    if (int'(env_o) < env_min) env_min = int'(env_o);
  endtask

  task automatic wait_strobe(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!strobe_o && cnt < budget);
    chk("strobe_timeout", int'(strobe_o), 1);
  endtask

  task automatic pulse_trigger();
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    hi_cnt    = 0;
    env_min   = 15;
    rst       = 1'b1;
    sample_i  = 8'd0;
    trigger_i = 1'b0;

    // 1: reset, then silence without trigger
    repeat (3) tick();
    chk("rst_pwm", int'(pwm_o), 0);
    chk("rst_active", int'(active_o), 0);
    chk("rst_env", int'(env_o), 0);
    chk("rst_strobe", int'(strobe_o), 0);
    rst      = 1'b0;
    sample_i = 8'd200;
    hi_cnt   = 0;
    bad      = 0;
    strobes  = 0;
    first_sb = 0;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (active_o || env_o != 4'd0) bad++;
      if (strobe_o) begin
        strobes++;
        if (first_sb == 0) first_sb = i;
      end
    end
    chk("idle_pwm_high", hi_cnt, 0);
    chk("idle_active_env", bad, 0);
    chk("first_strobe_tick", first_sb, 256);
    chk("idle_strobes", strobes, 7);

    // 2: attack to full level
    sample_i = 8'd255;
    pulse_trigger();
    chk("atk_active", int'(active_o), 1);
    chk("atk_env0", int'(env_o), 0);
    for (int k = 1; k <= 15; k++) begin
      wait_strobe(300, n);
      chk("atk_env", int'(env_o), k);
    end
    wait_strobe(300, n);
    hi_cnt  = 0;
    strobes = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (strobe_o) strobes++;
    end
    chk("full_duty_high", hi_cnt, 239);
    chk("period_strobes", strobes, 1);
    chk("period_end_strobe", int'(strobe_o), 1);

    // 3: rest of sustain, then release to idle
    for (int s = 3; s <= 64; s++) begin
      wait_strobe(300, n);
      chk("sus_env", int'(env_o), 15);
      chk("sus_active", int'(active_o), 1);
    end
    for (int r = 1; r <= 60; r++) begin
      wait_strobe(300, n);
      chk("rel_env", int'(env_o), 15 - r / 4);
      chk("rel_active", int'(active_o), (r < 60) ? 1 : 0);
    end
    wait_strobe(300, n);
    hi_cnt = 0;
    repeat (600) tick();
    chk("post_rel_pwm", hi_cnt, 0);
    chk("post_rel_active", int'(active_o), 0);

    // 4: retrigger during release at env 8
    pulse_trigger();
    for (int k = 1; k <= 107; k++) begin
      wait_strobe(300, n);
    end
    chk("rel_env8", int'(env_o), 8);
    pulse_trigger();
    chk("retrig_active", int'(active_o), 1);
    chk("retrig_env", int'(env_o), 8);
    env_min = 15;
    for (int k = 1; k <= 7; k++) begin
      wait_strobe(300, n);
      chk("retrig_ramp", int'(env_o), 8 + k);
    end
    chk("retrig_min", env_min, 8);

    // 5: reset mid-period while in sustain, trigger held meanwhile
    repeat (36) tick();
    chk("pre_rst_pwm", int'(pwm_o), 1);
    rst       = 1'b1;
    trigger_i = 1'b1;
    tick();
    rst       = 1'b0;
    trigger_i = 1'b0;
    chk("mid_rst_pwm", int'(pwm_o), 0);
    chk("mid_rst_env", int'(env_o), 0);
    chk("mid_rst_active", int'(active_o), 0);
    chk("mid_rst_strobe", int'(strobe_o), 0);
    wait_strobe(400, n);
    chk("rst_cnt_restart", n, 256);
    chk("rst_trig_ignored", int'(active_o), 0);

    // 6: silent sample ramps, then mid-period sample change
    sample_i = 8'd0;
    hi_cnt   = 0;
    pulse_trigger();
    chk("z_active", int'(active_o), 1);
    for (int k = 1; k <= 15; k++) begin
      wait_strobe(300, n);
    end
    chk("z_env", int'(env_o), 15);
    chk("z_pwm", hi_cnt, 0);
    repeat (10) tick();
    sample_i = 8'd128;
    wait_strobe(300, n);
    chk("glitch_free", hi_cnt, 0);
    hi_cnt = 0;
    repeat (256) tick();
    chk("duty_120", hi_cnt, 120);
    chk("duty_120_strobe", int'(strobe_o), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
